// File: rtl/pipe_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// pipe_mem_arbiter_if
// Bundle of every handshake/bus signal around the unified-memory arbiter:
// the IF-stage fetch request, the MEM-stage data request, the external memory
// handshake and the global pipeline stall / watchdog outputs.
//   slave  : arbiter view (takes requests and memory responses, drives results,
//            memory request and stall)
//   master : environment view (pipeline stages plus the external memory)
// Parameters: AW address width, DW data width.
// -----------------------------------------------------------------------------
interface pipe_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  // instruction fetch side
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  // data access side
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  // external memory handshake
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  // pipeline control / status
  logic          stall;
  logic          timeout_err;

  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall, timeout_err
  );

  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall, timeout_err
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_mem_arbiter
// Shares one single-ported memory between the instruction fetch and the data
// access of a pipelined CPU. Each pipeline step runs the data access first
// (older instruction), then the fetch, and holds the pipeline with a global
// stall until both results are captured. Results are presented for one cycle
// in DONE, where stall is released.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    pipe_mem_arbiter_if.slave: fetch request/result, data request/
//          result, memory handshake, stall and sticky timeout_err
// Parameters: AW, DW widths; TIMEOUT max wait cycles per memory transaction.
//
// Optional build macro MEMARB_TIMEOUT_EN: adds a per-transaction watchdog that
// aborts a transaction after TIMEOUT cycles without mem_ready, zeroes the
// affected read data, suppresses its valid and sets sticky timeout_err.
// Without it the arbiter waits indefinitely and timeout_err is tied to 0.
// -----------------------------------------------------------------------------
module pipe_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  pipe_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, INST = 2'd2, DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  // request snapshot taken in IDLE; later input changes are ignored
  logic          if_req_q, if_req_d;
  logic          d_rd_q, d_rd_d;
  logic          d_wr_q, d_wr_d;
  logic [AW-1:0] if_addr_q, if_addr_d;
  logic [AW-1:0] d_addr_q, d_addr_d;
  logic [DW-1:0] d_wdata_q, d_wdata_d;
  // results and per-step completion flags
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          tmo_hit;

  assign busy = (state_q == DATA) || (state_q == INST);

`ifdef MEMARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_err_q, timeout_err_d;

  // The cycle that would bring the wait count to TIMEOUT is the last one the
  // transaction is allowed; the state then advances as if mem_ready came.
  assign tmo_hit = busy & ~bus.mem_ready & (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q | tmo_hit;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (busy & ~bus.mem_ready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT > 0);
  assign tmo_hit            = 1'b0;
  assign bus.timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    if_req_d   = if_req_q;
    d_rd_d     = d_rd_q;
    d_wr_d     = d_wr_q;
    if_addr_d  = if_addr_q;
    d_addr_d   = d_addr_q;
    d_wdata_d  = d_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = if_done_q;
    d_done_d   = d_done_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        if_req_d  = bus.if_req;
        // read+write together is a plain write: no load result
        d_rd_d    = bus.d_read & ~bus.d_write;
        d_wr_d    = bus.d_write;
        if_addr_d = bus.if_addr;
        d_addr_d  = bus.d_addr;
        d_wdata_d = bus.d_wdata;
        if_done_d = 1'b0;
        d_done_d  = 1'b0;
        if (bus.d_read | bus.d_write) begin
          state_d = DATA;
        end else if (bus.if_req) begin
          state_d = INST;
        end
      end

      DATA: begin
        mem_req   = 1'b1;
        mem_we    = d_wr_q;
        mem_addr  = d_addr_q;
        mem_wdata = d_wdata_q;
        if (bus.mem_ready) begin
          if (d_rd_q) begin
            d_rdata_d = bus.mem_rdata;
          end
          d_done_d = 1'b1;
        end else if (tmo_hit) begin
          d_rdata_d = '0;
        end
        if (bus.mem_ready | tmo_hit) begin
          state_d = if_req_q ? INST : DONE;
        end
      end

      INST: begin
        mem_req  = 1'b1;
        mem_addr = if_addr_q;
        if (bus.mem_ready) begin
          if_rdata_d = bus.mem_rdata;
          if_done_d  = 1'b1;
          state_d    = DONE;
        end else if (tmo_hit) begin
          if_rdata_d = '0;
          state_d    = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      if_req_q   <= 1'b0;
      d_rd_q     <= 1'b0;
      d_wr_q     <= 1'b0;
      if_addr_q  <= '0;
      d_addr_q   <= '0;
      d_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_req_q   <= if_req_d;
      d_rd_q     <= d_rd_d;
      d_wr_q     <= d_wr_d;
      if_addr_q  <= if_addr_d;
      d_addr_q   <= d_addr_d;
      d_wdata_q  <= d_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_valid  = (state_q == DONE) & if_done_q;
  assign bus.d_valid   = (state_q == DONE) & d_done_q;

  // Released while reset is held so a request left asserted by the pipeline
  // cannot freeze it during reset.
  assign bus.stall = ~reset & (state_q != DONE) &
                     ((state_q != IDLE) | bus.if_req | bus.d_read | bus.d_write);

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
`timescale 1ns/1ps
module tb_pipe_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  pipe_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic ir; logic [31:0] ia; logic dr; logic dw; logic [31:0] da; logic [31:0] wd; int ld; int li;
  } step_in_t;
  typedef struct {
    int cycles; logic done; logic iv; logic dv; logic [31:0] ird; logic [31:0] drd; logic terr;
  } step_out_t;
  typedef struct {
    step_in_t s; int cyc; logic iv; logic dv; logic [31:0] ird; logic [31:0] drd;
    int ntx; logic [31:0] a0; logic we0;
  } vec_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } txn_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- external memory model ----------------
  logic [31:0] mem_arr [logic [31:0]];
  txn_t        log_q[$];
  int          lat_q[$];
  int          wcnt = 0;
  int          stab_err = 0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], 16'hBEEF};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : dflt(a);
  endfunction

  // Latency L counts from the first cycle of mem_req inclusive; an empty
  // latency queue means the memory never answers.
  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom();
    if (reset || !bus.mem_req) begin
      wcnt = 0;
    end else begin
      if (wcnt > 0 && (bus.mem_addr !== prev_addr || bus.mem_we !== prev_we ||
                       bus.mem_wdata !== prev_wdata)) stab_err++;
      prev_addr  = bus.mem_addr;
      prev_we    = bus.mem_we;
      prev_wdata = bus.mem_wdata;
      wcnt++;
      if (lat_q.size() > 0 && wcnt >= lat_q[0]) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_rd(bus.mem_addr);
        if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
        log_q.push_back('{addr: bus.mem_addr, we: bus.mem_we, wdata: bus.mem_wdata});
        void'(lat_q.pop_front());
        wcnt = 0;
      end
    end
  end

  // ---------------- reference model (behavioural) ----------------
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic step_in_t mk_in(input logic ir, input logic [31:0] ia, input logic dr,
                                     input logic dw, input logic [31:0] da, input logic [31:0] wd,
                                     input int ld, input int li);
    step_in_t s;
    s.ir = ir; s.ia = ia; s.dr = dr; s.dw = dw; s.da = da; s.wd = wd; s.ld = ld; s.li = li;
    return s;
  endfunction

  // Starts at posedge+1 in IDLE; returns at posedge+1 after DONE, requests dropped.
  task automatic do_step(input step_in_t s, output step_out_t o);
    log_q.delete();
    bus.if_req = s.ir; bus.if_addr = s.ia;
    bus.d_read = s.dr; bus.d_write = s.dw; bus.d_addr = s.da; bus.d_wdata = s.wd;
    if (s.dr | s.dw) lat_q.push_back(s.ld);
    if (s.ir) lat_q.push_back(s.li);
    o = '{cycles: 0, done: 1'b0, iv: 1'b0, dv: 1'b0, ird: '0, drd: '0, terr: 1'b0};
    while (!o.done && o.cycles < 100) begin
      @(negedge clk); #1;
      o.cycles++;
      if (!bus.stall) begin
        o.done = 1'b1; o.iv = bus.if_valid; o.dv = bus.d_valid;
        o.ird = bus.if_rdata; o.drd = bus.d_rdata; o.terr = bus.timeout_err;
      end
      @(posedge clk); #1;
    end
    bus.if_req = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vec[6];
  step_out_t   o;
  step_in_t    s;
  txn_t        exp_q[$];
  logic [31:0] exp_ird, exp_drd;
  int          exp_cyc, k;

  initial begin
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    mem_arr[32'h40]  = 32'h8C22_0004;
    mem_arr[32'h44]  = 32'hAC03_0008;
    mem_arr[32'h100] = 32'h0000_1234;

    // -------- reset state --------
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_valids", {30'd0, bus.if_valid, bus.d_valid}, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    @(posedge clk); #1;

    // -------- table-driven directed steps --------
    vec[0] = '{s: mk_in(1, 32'h40, 0, 0, 0, 0, 1, 1), cyc: 3, iv: 1, dv: 0,
               ird: 32'h8C22_0004, drd: 32'h0, ntx: 1, a0: 32'h40, we0: 0};
    vec[1] = '{s: mk_in(1, 32'h44, 1, 0, 32'h100, 0, 2, 2), cyc: 6, iv: 1, dv: 1,
               ird: 32'hAC03_0008, drd: 32'h1234, ntx: 2, a0: 32'h100, we0: 0};
    vec[2] = '{s: mk_in(0, 0, 0, 1, 32'h200, 32'hCAFE_F00D, 3, 1), cyc: 5, iv: 0, dv: 1,
               ird: 32'hAC03_0008, drd: 32'h1234, ntx: 1, a0: 32'h200, we0: 1};
    vec[3] = '{s: mk_in(1, 32'h40, 1, 1, 32'h300, 32'h5555_AAAA, 1, 1), cyc: 4, iv: 1, dv: 1,
               ird: 32'h8C22_0004, drd: 32'h1234, ntx: 2, a0: 32'h300, we0: 1};
    vec[4] = '{s: mk_in(0, 0, 1, 0, 32'h200, 0, 1, 1), cyc: 3, iv: 0, dv: 1,
               ird: 32'h8C22_0004, drd: 32'hCAFE_F00D, ntx: 1, a0: 32'h200, we0: 0};
    vec[5] = '{s: mk_in(1, 32'h44, 1, 0, 32'h300, 0, 4, 1), cyc: 7, iv: 1, dv: 1,
               ird: 32'hAC03_0008, drd: 32'h5555_AAAA, ntx: 2, a0: 32'h300, we0: 0};
    for (int i = 0; i < 6; i++) begin
      do_step(vec[i].s, o);
      $display("vec %0d: cycles=%0d if_valid=%0b d_valid=%0b if_rdata=%08h d_rdata=%08h",
               i, o.cycles, o.iv, o.dv, o.ird, o.drd);
      check("vec_cycles", o.cycles, vec[i].cyc);
      check("vec_if_valid", {31'd0, o.iv}, {31'd0, vec[i].iv});
      check("vec_d_valid", {31'd0, o.dv}, {31'd0, vec[i].dv});
      check("vec_if_rdata", o.ird, vec[i].ird);
      check("vec_d_rdata", o.drd, vec[i].drd);
      check("vec_txn_count", log_q.size(), vec[i].ntx);
      if (log_q.size() > 0) begin
        check("vec_first_addr", log_q[0].addr, vec[i].a0);
        check("vec_first_we", {31'd0, log_q[0].we}, {31'd0, vec[i].we0});
      end
      if (vec[i].ntx == 2 && log_q.size() == 2)
        check("vec_second_addr", log_q[1].addr, vec[i].s.ia);
    end
    check("vec_write_data", mem_rd(32'h200), 32'hCAFE_F00D);

    // -------- stalled memory: watchdog or indefinite wait --------
`ifdef MEMARB_TIMEOUT_EN
    do_step(mk_in(1, 32'h4C, 0, 0, 0, 0, 1, 1000), o);
    lat_q.delete();
    $display("timeout step: cycles=%0d if_valid=%0b if_rdata=%08h timeout_err=%0b",
             o.cycles, o.iv, o.ird, o.terr);
    check("tmo_cycles", o.cycles, 2 + TIMEOUT);
    check("tmo_if_valid", {31'd0, o.iv}, 32'd0);
    check("tmo_if_rdata", o.ird, 32'd0);
    check("tmo_err", {31'd0, o.terr}, 32'd1);
    do_step(mk_in(1, 32'h40, 0, 0, 0, 0, 1, 1), o);
    $display("post-timeout step: cycles=%0d if_rdata=%08h timeout_err=%0b", o.cycles, o.ird, o.terr);
    check("tmo_sticky", {31'd0, o.terr}, 32'd1);
    check("tmo_recover_rdata", o.ird, 32'h8C22_0004);
`else
    log_q.delete();
    bus.if_req = 1'b1; bus.if_addr = 32'h4C;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;
    $display("hang wait: stall=%0b mem_req=%0b timeout_err=%0b", bus.stall, bus.mem_req, bus.timeout_err);
    check("hang_stall", {31'd0, bus.stall}, 32'd1);
    check("hang_mem_req", {31'd0, bus.mem_req}, 32'd1);
    check("hang_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    lat_q.push_back(1);
    k = 0;
    while (bus.stall && k < 10) begin
      @(negedge clk); #1; k++;
    end
    check("hang_release", {31'd0, bus.stall}, 32'd0);
    check("hang_if_valid", {31'd0, bus.if_valid}, 32'd1);
    check("hang_if_rdata", bus.if_rdata, 32'h004C_BEEF);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
`endif

    // -------- reset in the middle of a data access --------
    log_q.delete();
    bus.d_read = 1'b1; bus.d_addr = 32'h400; bus.if_req = 1'b1; bus.if_addr = 32'h48;
    lat_q.push_back(1000);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("midrst_pre_req", {31'd0, bus.mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    $display("mid reset: mem_req=%0b stall=%0b mem_addr=%08h d_rdata=%08h",
             bus.mem_req, bus.stall, bus.mem_addr, bus.d_rdata);
    check("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("midrst_stall", {31'd0, bus.stall}, 32'd0);
    check("midrst_mem_addr", bus.mem_addr, 32'd0);
    check("midrst_rdata", bus.d_rdata | bus.if_rdata, 32'd0);
    check("midrst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    lat_q.delete();
    bus.d_read = 1'b0; bus.if_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    check("midrst_idle_req", {31'd0, bus.mem_req}, 32'd0);
    check("midrst_idle_stall", {31'd0, bus.stall}, 32'd0);
    check("midrst_no_result", log_q.size(), 32'd0);
    @(posedge clk); #1;
    do_step(mk_in(1, 32'h40, 0, 0, 0, 0, 1, 1), o);
    $display("after reset step: cycles=%0d if_rdata=%08h", o.cycles, o.ird);
    check("midrst_recover_cycles", o.cycles, 3);
    check("midrst_recover_rdata", o.ird, 32'h8C22_0004);

    // -------- randomized steps against the behavioural model --------
    exp_ird = 32'h8C22_0004;
    exp_drd = 32'h0;
    for (int n = 0; n < 40; n++) begin
      s.ir = 1'($urandom_range(0, 1));
      s.dr = 1'($urandom_range(0, 1));
      s.dw = 1'($urandom_range(0, 1));
      if (!s.ir && !s.dr && !s.dw) s.ir = 1'b1;
      s.ia = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      s.da = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      s.wd = $urandom();
      s.ld = int'($urandom_range(1, 4));
      s.li = int'($urandom_range(1, 4));
      // model: data access strictly before fetch, one memory op each
      exp_q.delete();
      exp_cyc = 2;
      if (s.dr || s.dw) begin
        exp_cyc += s.ld;
        exp_q.push_back('{addr: s.da, we: s.dw, wdata: s.wd});
        if (s.dw) ref_mem[s.da] = s.wd;
        else exp_drd = ref_rd(s.da);
      end
      if (s.ir) begin
        exp_cyc += s.li;
        exp_q.push_back('{addr: s.ia, we: 1'b0, wdata: 32'h0});
        exp_ird = ref_rd(s.ia);
      end
      do_step(s, o);
      $display("rnd %0d: ir=%0b dr=%0b dw=%0b cycles=%0d if_rdata=%08h d_rdata=%08h",
               n, s.ir, s.dr, s.dw, o.cycles, o.ird, o.drd);
      check("rnd_cycles", o.cycles, exp_cyc);
      check("rnd_if_valid", {31'd0, o.iv}, {31'd0, s.ir});
      check("rnd_d_valid", {31'd0, o.dv}, {31'd0, s.dr | s.dw});
      check("rnd_if_rdata", o.ird, exp_ird);
      check("rnd_d_rdata", o.drd, exp_drd);
      check("rnd_txn_count", log_q.size(), exp_q.size());
      for (int t = 0; t < exp_q.size() && t < log_q.size(); t++) begin
        check("rnd_txn_addr", log_q[t].addr, exp_q[t].addr);
        check("rnd_txn_we", {31'd0, log_q[t].we}, {31'd0, exp_q[t].we});
        if (exp_q[t].we) check("rnd_txn_wdata", log_q[t].wdata, exp_q[t].wdata);
      end
    end

    check("mem_bus_stable", stab_err, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_mem_arbiter.md
# pipe_mem_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the instruction-fetch stage and the data-memory stage of the pipelined MIPS CPU. Each pipeline step it services the pending data access first (older instruction), then the instruction fetch. It captures both read results and holds the whole pipeline with a global stall until both are complete. It sits between the IF/MEM stage logic (data requests driven by the MemRead/MemWrite control bits) and the external memory handshake.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, max wait cycles per memory transaction (used only with MEMARB_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request (level, held while stalled)
- if_addr  in  AW  fetch address (PC)
- if_rdata  out  DW  registered instruction word
- if_valid  out  1  fetch completed this step
- d_read  in  1  data load request (MemRead)
- d_write  in  1  data store request (MemWrite)
- d_addr  in  AW  data address (ALU result)
- d_wdata  in  DW  store data
- d_rdata  out  DW  registered load data
- d_valid  out  1  data access completed this step
- mem_req  out  1  memory transaction request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  memory completes transaction this cycle
- stall  out  1  freeze all pipeline registers and PC
- timeout_err  out  1  sticky watchdog flag

## Operation
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- States: IDLE, DATA, INST, DONE.
- Reset: state=IDLE. All outputs are 0: if_rdata, d_rdata, if_valid, d_valid, mem_req, mem_we, mem_addr, mem_wdata, timeout_err. stall is 0 while no request is present.
- Reset mid-transaction: mem_req drops immediately. No result is delivered.
- IDLE:
  - if d_read|d_write, go to DATA.
  - else if if_req, go to INST.
  - else stay in IDLE.
- DATA:
  - Outputs: mem_req=1, mem_addr=d_addr, mem_we=d_write, mem_wdata=d_wdata.
  - On mem_ready: if d_read, d_rdata<=mem_rdata.
  - Then go to INST if if_req is set, else go to DONE.
- INST:
  - Outputs: mem_req=1, mem_we=0, mem_addr=if_addr.
  - On mem_ready: if_rdata<=mem_rdata, then go to DONE.
- DONE:
  - stall=0 for exactly one cycle.
  - if_valid=1 if INST completed this step; d_valid=1 if DATA completed this step.
  - Next state is IDLE.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_req is 0 in IDLE and DONE.
  - mem_ready is ignored when mem_req=0.
- stall = (state!=DONE) & ((state!=IDLE) | if_req | d_read | d_write). It is combinational from state and requests.
- d_read and d_write both set: treated as a write. d_rdata is unchanged.
- A store in DATA leaves d_rdata unchanged. d_valid is still 1 in DONE.
- if_rdata and d_rdata hold their last value until overwritten.
- Request inputs are sampled only in IDLE. Changes in other states are ignored until the next IDLE.

## Timing
- Memory latency: L = cycles from mem_req rise to mem_ready inclusive, L≥1.
- Step length:
  - fetch + data: 1 (IDLE) + L_d + L_i + 1 (DONE)
  - fetch only: 2 + L_i
  - minimum with zero-wait memory: 4 cycles with data, 3 without
- Results become valid on the first cycle of DONE and are registered. The pipeline latches them on that cycle's rising edge at the end of DONE.
- Back-to-back steps: DONE is followed by IDLE. There is no bubble beyond the IDLE cycle.

## Configuration
- MEMARB_TIMEOUT_EN defined:
  - A 4-bit+ counter clears on entry to DATA or INST and increments each cycle that mem_ready=0.
  - When the counter reaches TIMEOUT, the transaction aborts:
    - the corresponding rdata is forced to 0 and its valid bit is 0
    - the state advances as if mem_ready had arrived
    - timeout_err is set and stays 1 until reset
- MEMARB_TIMEOUT_EN undefined:
  - No counter. The arbiter waits indefinitely for mem_ready.
  - timeout_err is tied to 0.

## Test plan
- Reset asserted mid-DATA with mem_req=1 → mem_req, stall and all outputs 0 asynchronously; state IDLE after release.
- if_req=1, if_addr=0x40, zero-wait memory returning 0x8C220004 → IDLE, INST, DONE. stall=1,1,0. if_valid=1 and if_rdata=0x8C220004 in DONE.
- d_read=1 at d_addr=0x100 (mem returns 0x1234) plus if_req=1 at 0x44 (returns 0xAC030008), mem_ready after 2 cycles each → DATA then INST ordering. mem_addr 0x100 then 0x44. Step length 6. d_rdata=0x1234, if_rdata=0xAC030008, both valid in DONE.
- d_write=1, d_addr=0x200, d_wdata=0xCAFEF00D → mem_we=1 with the address and data stable through the wait. d_rdata unchanged. d_valid=1 in DONE.
- d_read=1 and d_write=1 together → single write transaction with mem_we=1. d_rdata unchanged.
- MEMARB_TIMEOUT_EN, mem_ready held 0 in INST → abort after 15 cycles. if_valid=0, if_rdata=0, timeout_err=1 and sticky. Without the macro, stall stays 1 indefinitely.
